ctr_ctrl: RTL
=============

# ctr_ctrl

Upstream control stage for the `ctr` up/down counter. It takes three raw, asynchronous push-button inputs (run/pause, direction, single-step) and turns them into clean `enable` and `count_reversed` signals that drive `ctr` directly. Each button is synchronised and debounced, and a small state machine decides when the counter advances and in which direction.

## Interface
- `DEBOUNCE_CYCLES`, default 4, is the number of consecutive cycles a synchronised input must differ from its stable value before it is accepted. The legal range is 1 to 2^20.
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset. It asserts asynchronously and is released synchronously to `clk` by the system.
- `btn_run`, input, 1 bit: raw, asynchronous. A press toggles between run and pause.
- `btn_dir`, input, 1 bit: raw, asynchronous. A press toggles the count direction.
- `btn_step`, input, 1 bit: raw, asynchronous. A press while paused advances `ctr` by exactly one count.
- `enable`, output, 1 bit: to `ctr.enable`. Registered.
- `count_reversed`, output, 1 bit: to `ctr.count_reversed`. 1 means descending. Registered.
- `running`, output, 1 bit: status, 1 while in RUN. Registered.

## Operation
- **Per-button conditioning:**
  - 2-FF synchroniser, followed by a debounce counter and a `stable` register.
  - When the synchronised value differs from `stable`, the counter increments. When it equals `stable`, the counter clears.
  - When the counter would reach `DEBOUNCE_CYCLES`, `stable` takes the synchronised value and the counter clears.
  - A press event is a 1-cycle pulse equal to `stable & ~stable_q`, where `stable_q` is `stable` delayed one cycle.
  - Releases produce no event.
- **Direction flag `dir`:**
  - Toggles on each `dir` press event, in any state.
  - `count_reversed` = `dir`.
- **FSM states:** IDLE (paused), RUN, STEP.
  - IDLE: run event goes to RUN; otherwise a step event goes to STEP; otherwise stay in IDLE. If run and step events occur in the same cycle, run wins and the step is dropped.
  - RUN: run event goes to IDLE. Step events are ignored.
  - STEP: unconditionally returns to IDLE after one cycle. A run event arriving in STEP goes to RUN instead.
- **Outputs are registered from the next state:**
  - `enable` = 1 in RUN or STEP.
  - `running` = 1 in RUN.
  - A direction change while in RUN takes effect without dropping `enable`.
- **Reset values:** `enable`=0, `count_reversed`=0, `running`=0, FSM=IDLE, all `stable`=0, synchronisers=0, debounce counters=0.
- **Reset mid-debounce or mid-step:** all partial progress is discarded. No event fires after release until a fresh press has been fully debounced.

## Timing
- Raw press first sampled high at rising edge k and held: `stable` rises at edge k+1+`DEBOUNCE_CYCLES`, and the outputs change at edge k+2+`DEBOUNCE_CYCLES`.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- A held button produces exactly one event.
- A STEP pulse drives `enable` high for exactly one clock period, so `ctr` advances by exactly 1.
- A `dir` event and a run/step event in the same cycle are both applied in that cycle.

## Structure
- Package `ctr_pkg` holds:
  - the state typedef (IDLE, RUN, STEP, 2-bit encoding);
  - the debounce-counter width function, `$clog2(DEBOUNCE_CYCLES+1)`.
- Sub-module `btn_debounce` (synchroniser, debounce counter, `stable`, press pulse) is instantiated three times.
- `ctr_ctrl` contains the three `btn_debounce` instances, the `dir` flag, the FSM and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, with `ctr` WIDTH=3 attached downstream.
- **Reset:** hold `rst`=0 with all buttons toggling → `enable`=0, `count_reversed`=0, `running`=0 throughout. After release, `count` stays at 0 for 20 cycles.
- **Run press:** hold `btn_run`=1 from edge k → `enable`=1 and `running`=1 at edge k+6. `count` then reads 1, 2, … 7, 0 on successive edges.
- **Glitch rejection:** 3-cycle pulse on `btn_run` → no state change. A 2-cycle low dropout during a held press → exactly one event.
- **Step:** paused with `count`=5, press `btn_step` → `enable` is high for exactly one cycle and `count`=6. Holding `btn_step` for 50 cycles yields only that single increment.
- **Direction while running:** in RUN with `count`=3, press `btn_dir` → `count_reversed`=1 at k+6 with `enable` still 1. `count` then descends 2, 1, 0, 7 (wrap-around).
- **Simultaneous and mid-operation reset:**
  - Run and step events in the same cycle while in IDLE → RUN, no extra step.
  - `rst`=0 asserted during a debounce count, then released → no event until a fresh 4-cycle press.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types and helpers for the ctr control stage.
package ctr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } ctr_state_e;

  // Debounce counter width, wide enough to hold the value DEBOUNCE_CYCLES.
  function automatic int unsigned dbnc_cnt_width(int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces one raw push-button; emits a 1-cycle pulse on each accepted press.
module btn_debounce
  import ctr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = dbnc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            stable_dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= 2'b00;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn_i};
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

  // Any cycle agreeing with the stable value restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q + CntOne == CntMax) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  assign press_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/ctr_ctrl.sv
// Button front-end for the ctr counter: debounced run/pause, direction and single-step control.
module ctr_ctrl
  import ctr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_dir,
  input  logic btn_step,
  output logic enable,
  output logic count_reversed,
  output logic running
);

  logic run_evt, dir_evt, step_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (btn_run),
    .press_o(run_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (btn_dir),
    .press_o(dir_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (btn_step),
    .press_o(step_evt)
  );

  ctr_state_e state_q, state_d;
  logic       dir_q, dir_d;
  logic       enable_q, enable_d;
  logic       running_q, running_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      enable_q  <= enable_d;
      running_q <= running_d;
    end
  end

  // Run beats step when both arrive together in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run_evt) begin
          state_d = StRun;
        end else if (step_evt) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (run_evt) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = run_evt ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    enable_d  = (state_d == StRun) || (state_d == StStep);
    running_d = (state_d == StRun);
    dir_d     = dir_q ^ dir_evt;
  end

  assign enable         = enable_q;
  assign running        = running_q;
  assign count_reversed = dir_q;

endmodule
